// File: rtl/int_timer_pkg.sv
// Shared definitions for the interrupt_timer block: register map offsets,
// CTRL bit positions, FSM state encoding and the saturating miss counter step.
// Optional feature macro: INT_TIMER_COUNT_READ_EN (see interrupt_timer.sv).
package int_timer_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PERIOD = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Missed-interrupt counter sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/int_timer_regs.sv
// Port-bus front end of the interrupt timer: address decode, CTRL/PERIOD
// registers, clear-missed pulse and the combinational read mux.
// With INT_TIMER_COUNT_READ_EN the live count is readable at +3 and a read
// strobe on STATUS clears the missed counter.
module int_timer_regs
  import int_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0010,
  parameter logic [15:0] PERIOD_RST = 16'd1000,
  parameter logic        EN_RST     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] port_id,
  input  logic [15:0] out_port,
  input  logic        write_strobe,
  input  logic        read_strobe,
  input  logic [7:0]  missed,
  input  logic        irq,
  input  logic [15:0] count,
  output logic        enable,
  output logic [15:0] period,
  output logic        active_nxt,
  output logic        period_wr,
  output logic        clear_missed,
  output logic [15:0] rd_data,
  output logic        rd_hit
);

`ifdef INT_TIMER_COUNT_READ_EN
  localparam logic [15:0] NUM_REGS = 16'd4;
`else
  localparam logic [15:0] NUM_REGS = 16'd3;
`endif

  logic [15:0] offset;
  logic [1:0]  off;
  logic        in_range;
  logic        ctrl_wr;
  logic        enable_q, enable_d;
  logic [15:0] period_q, period_d;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap out of range.
  assign offset    = port_id - BASE_ADDR;
  assign off       = offset[1:0];
  assign in_range  = (offset < NUM_REGS);
  assign ctrl_wr   = write_strobe && in_range && (off == OFF_CTRL);
  assign period_wr = write_strobe && in_range && (off == OFF_PERIOD);
  assign rd_hit    = in_range;

`ifdef INT_TIMER_COUNT_READ_EN
  assign clear_missed = (ctrl_wr && out_port[CTRL_CLR_BIT]) ||
                        (read_strobe && in_range && (off == OFF_STATUS));
`else
  logic unused_inputs;
  assign unused_inputs = read_strobe ^ (^count);
  assign clear_missed  = ctrl_wr && out_port[CTRL_CLR_BIT];
`endif

  // Next values of the software-visible control registers.
  always_comb begin
    enable_d = enable_q;
    period_d = period_q;
    if (ctrl_wr)   enable_d = out_port[CTRL_EN_BIT];
    if (period_wr) period_d = out_port;
  end

  // Control register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= EN_RST;
      period_q <= PERIOD_RST;
    end else begin
      enable_q <= enable_d;
      period_q <= period_d;
    end
  end

  assign enable     = enable_q;
  assign period     = period_q;
  // The FSM tracks whether the timer will be running next cycle so that
  // counting starts the very cycle a write takes effect.
  assign active_nxt = enable_d && (period_d != 16'd0);

  // Read mux feeding the core's IN_PORT selection.
  always_comb begin
    rd_data = 16'h0000;
    if (in_range) begin
      case (off)
        OFF_CTRL:   rd_data = {14'b0, enable_q, 1'b0};
        OFF_PERIOD: rd_data = period_q;
        OFF_STATUS: rd_data = {missed, 6'b0, enable_q, irq};
`ifdef INT_TIMER_COUNT_READ_EN
        OFF_COUNT:  rd_data = count;
`endif
        default:    rd_data = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/interrupt_timer.sv
// Periodic interrupt source for tramelblaze_top. Raises INTERRUPT every
// PERIOD cycles while enabled, drops it on INTERRUPT_ACK, and counts periods
// that elapsed while an interrupt was still pending.
// Optional feature macro: INT_TIMER_COUNT_READ_EN (count readback at +3,
// read-to-clear of the missed counter via STATUS).
module interrupt_timer
  import int_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0010,
  parameter logic [15:0] PERIOD_RST = 16'd1000,
  parameter logic        EN_RST     = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] PORT_ID,
  input  logic [15:0] OUT_PORT,
  input  logic        WRITE_STROBE,
  input  logic        READ_STROBE,
  input  logic        INTERRUPT_ACK,
  output logic [15:0] RD_DATA,
  output logic        RD_HIT,
  output logic        INTERRUPT
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  missed_q, missed_d;
  logic        irq_q, irq_d;

  logic        enable;
  logic [15:0] period;
  logic        active_nxt;
  logic        period_wr;
  logic        clear_missed;
  logic        active;
  logic        term;
  logic        ack;

  int_timer_regs #(
    .BASE_ADDR  (BASE_ADDR),
    .PERIOD_RST (PERIOD_RST),
    .EN_RST     (EN_RST)
  ) u_regs (
    .clk          (CLK),
    .rst          (RESET),
    .port_id      (PORT_ID),
    .out_port     (OUT_PORT),
    .write_strobe (WRITE_STROBE),
    .read_strobe  (READ_STROBE),
    .missed       (missed_q),
    .irq          (irq_q),
    .count        (count_q),
    .enable       (enable),
    .period       (period),
    .active_nxt   (active_nxt),
    .period_wr    (period_wr),
    .clear_missed (clear_missed),
    .rd_data      (RD_DATA),
    .rd_hit       (RD_HIT)
  );

  assign active = enable && (period != 16'd0);
  assign term   = active && (count_q == period - 16'd1);
  assign ack    = INTERRUPT_ACK && irq_q;

  // Next-state, counter and interrupt/miss bookkeeping.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    missed_d = missed_q;
    // A period write restarts the count, so a shorter period never fires early.
    count_d  = (period_wr || !active || term) ? 16'd0 : count_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (ack)        irq_d   = 1'b0;
        if (active_nxt) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (term) begin
          irq_d   = 1'b1;
          state_d = ST_PEND;
        end else if (!active_nxt) begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        // A new period beats a late ack: the request stays up, no miss charged.
        if (term) begin
          if (!ack) missed_d = sat_inc8(missed_q);
        end else if (ack) begin
          irq_d   = 1'b0;
          state_d = active_nxt ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_missed) missed_d = 8'd0;
  end

  // State, counter and interrupt registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      count_q  <= 16'd0;
      missed_q <= 8'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      missed_q <= missed_d;
      irq_q    <= irq_d;
    end
  end

  assign INTERRUPT = irq_q;

endmodule

// File: tb/tb_interrupt_timer.sv
// Self-checking bench for interrupt_timer: directed scenarios followed by a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_interrupt_timer;

  localparam logic [15:0] B = 16'h0010;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] PORT_ID = 16'h0000;
  logic [15:0] OUT_PORT = 16'h0000;
  logic        WRITE_STROBE = 1'b0;
  logic        READ_STROBE = 1'b0;
  logic        INTERRUPT_ACK = 1'b0;
  logic [15:0] RD_DATA;
  logic        RD_HIT;
  logic        INTERRUPT;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic        m_en;
  logic [15:0] m_per;
  logic [15:0] m_cnt;
  logic        m_int;
  logic [7:0]  m_missed;

  interrupt_timer #(
    .BASE_ADDR  (B),
    .PERIOD_RST (16'd1000),
    .EN_RST     (1'b0)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PORT_ID       (PORT_ID),
    .OUT_PORT      (OUT_PORT),
    .WRITE_STROBE  (WRITE_STROBE),
    .READ_STROBE   (READ_STROBE),
    .INTERRUPT_ACK (INTERRUPT_ACK),
    .RD_DATA       (RD_DATA),
    .RD_HIT        (RD_HIT),
    .INTERRUPT     (INTERRUPT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    logic act, tc, ak, clr, wr_ctrl, wr_per;
    logic [15:0] n_cnt;
    logic        n_int;
    logic [7:0]  n_missed;
    if (RESET) begin
      m_en = 1'b0; m_per = 16'd1000; m_cnt = 16'd0; m_int = 1'b0; m_missed = 8'd0;
      return;
    end
    act     = m_en && (m_per != 0);
    tc      = act && (m_cnt == m_per - 16'd1);
    ak      = INTERRUPT_ACK && m_int;
    wr_ctrl = WRITE_STROBE && (PORT_ID == B);
    wr_per  = WRITE_STROBE && (PORT_ID == B + 16'd1);
    clr     = wr_ctrl && OUT_PORT[1];
`ifdef INT_TIMER_COUNT_READ_EN
    clr     = clr || (READ_STROBE && (PORT_ID == B + 16'd2));
`endif
    n_cnt = (wr_per || !act || tc) ? 16'd0 : m_cnt + 16'd1;
    n_int = tc ? 1'b1 : (ak ? 1'b0 : m_int);
    n_missed = m_missed;
    if (tc && m_int && !ak && m_missed != 8'hFF) n_missed = m_missed + 8'd1;
    if (clr) n_missed = 8'd0;
    if (wr_ctrl) m_en = OUT_PORT[0];
    if (wr_per) m_per = OUT_PORT;
    m_cnt = n_cnt; m_int = n_int; m_missed = n_missed;
  endtask

  // Apply one cycle of bus/ack activity, then compare INTERRUPT and STATUS.
  task automatic step(input logic wr, input logic [15:0] id, input logic [15:0] d,
                      input logic ak, input logic rd);
    WRITE_STROBE = wr; PORT_ID = id; OUT_PORT = d; INTERRUPT_ACK = ak; READ_STROBE = rd;
    @(posedge CLK);
    model_step();
    #1;
    WRITE_STROBE = 1'b0; READ_STROBE = 1'b0; INTERRUPT_ACK = 1'b0; PORT_ID = B + 16'd2;
    #1;
    check("irq", {15'b0, INTERRUPT}, {15'b0, m_int});
    check("status", RD_DATA, {m_missed, 6'b0, m_en, m_int});
`ifdef INT_TIMER_COUNT_READ_EN
    PORT_ID = B + 16'd3;
    #1;
    check("count_rd", RD_DATA, m_cnt);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, B + 16'd2, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [15:0] d);
    step(1'b1, B + {14'b0, off}, d, 1'b0, 1'b0);
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [15:0] exp,
                          input logic exp_hit);
    PORT_ID = addr;
    #1;
    check(tag, RD_DATA, exp);
    check({tag, "_hit"}, {15'b0, RD_HIT}, {15'b0, exp_hit});
  endtask

  int waited;
  logic [7:0] missed_before;
  logic [15:0] r;

  initial begin
    // 1. reset
    for (int i = 0; i < 10; i++) step(1'b0, B, 16'h0, 1'b0, 1'b0);
    RESET = 1'b0;
    idle(1);
    check("rst_irq", {15'b0, INTERRUPT}, 16'h0000);
    rd_check("rst_period", B + 16'd1, 16'd1000, 1'b1);
    rd_check("rst_status", B + 16'd2, 16'h0000, 1'b1);
    rd_check("rst_ctrl", B, 16'h0000, 1'b1);
    rd_check("below_base", B - 16'd1, 16'h0000, 1'b0);
    rd_check("above_map", B + 16'd4, 16'h0000, 1'b0);
`ifdef INT_TIMER_COUNT_READ_EN
    rd_check("count_hit", B + 16'd3, 16'h0000, 1'b1);
`else
    rd_check("count_nohit", B + 16'd3, 16'h0000, 1'b0);
`endif

    // 2. period 10: rise 10 cycles after enable, ack, next rise 10 after previous
    wr_reg(2'd1, 16'd10);
    rd_check("period10", B + 16'd1, 16'd10, 1'b1);
    wr_reg(2'd0, 16'h0001);
    rd_check("ctrl_en", B, 16'h0002, 1'b1);
    waited = 0;
    while (INTERRUPT !== 1'b1 && waited < 50) begin idle(1); waited++; end
    check("first_rise_cycles", waited[15:0], 16'd10);
    idle(2);
    step(1'b0, B + 16'd2, 16'h0, 1'b1, 1'b0);
    check("ack_falls", {15'b0, INTERRUPT}, 16'h0000);
    waited = 3;
    while (INTERRUPT !== 1'b1 && waited < 50) begin idle(1); waited++; end
    check("second_rise_cycles", waited[15:0], 16'd10);
    step(1'b0, B + 16'd2, 16'h0, 1'b1, 1'b0);

    // 3. period 4 without acks: four misses, then clear keeps enable
    wr_reg(2'd1, 16'd4);
    idle(20);
    rd_check("missed4", B + 16'd2, 16'h0403, 1'b1);
    wr_reg(2'd0, 16'h0003);
    r = RD_DATA;
    check("missed_cleared", {8'h00, r[15:8]}, 16'h0000);
    check("enable_kept", {15'b0, r[1]}, 16'h0001);

    // 4. ack in the exact terminal-count cycle
    waited = 0;
    while (!(m_int && m_en && m_per != 0 && m_cnt == m_per - 16'd1) && waited < 20) begin
      idle(1); waited++;
    end
    missed_before = m_missed;
    step(1'b0, B + 16'd2, 16'h0, 1'b1, 1'b0);
    check("tc_ack_irq", {15'b0, INTERRUPT}, 16'h0001);
    rd_check("tc_ack_missed", B + 16'd2, {missed_before, 8'h03}, 1'b1);
    step(1'b0, B + 16'd2, 16'h0, 1'b1, 1'b0);

    // 5. saturate missed with period 1, then period 0 stops interrupts
    wr_reg(2'd1, 16'd1);
    idle(300);
    r = RD_DATA;
    check("missed_sat", {8'h00, r[15:8]}, 16'h00FF);
    wr_reg(2'd1, 16'd0);
    step(1'b0, B + 16'd2, 16'h0, 1'b1, 1'b0);
    idle(20);
    check("period0_quiet", {15'b0, INTERRUPT}, 16'h0000);
    rd_check("period0_missed", B + 16'd2, 16'hFF02, 1'b1);

    // 6. reset while pending
    wr_reg(2'd1, 16'd3);
    waited = 0;
    while (INTERRUPT !== 1'b1 && waited < 20) begin idle(1); waited++; end
    check("pend_before_rst", {15'b0, INTERRUPT}, 16'h0001);
    RESET = 1'b1;
    idle(1);
    RESET = 1'b0;
    check("rst_drops_irq", {15'b0, INTERRUPT}, 16'h0000);
    rd_check("rst2_period", B + 16'd1, 16'd1000, 1'b1);
    rd_check("rst2_status", B + 16'd2, 16'h0000, 1'b1);

`ifdef INT_TIMER_COUNT_READ_EN
    // count readback and read-to-clear of missed
    wr_reg(2'd1, 16'd100);
    wr_reg(2'd0, 16'h0001);
    idle(7);
    rd_check("count_live", B + 16'd3, 16'd7, 1'b1);
    wr_reg(2'd1, 16'd2);
    idle(10);
    step(1'b0, B + 16'd2, 16'h0, 1'b0, 1'b1);
    r = RD_DATA;
    check("rd_clear_missed", {8'h00, r[15:8]}, 16'h0000);
`endif

    // randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic ak;
      sel = int'($urandom_range(0, 99));
      ak  = ($urandom_range(0, 3) == 0);
      if (sel < 5)
        step(1'b1, B + 16'd1, 16'($urandom_range(0, 12)), ak, 1'b0);
      else if (sel < 9)
        step(1'b1, B, {14'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0)}, ak, 1'b0);
      else if (sel < 12)
        step(1'b0, B + 16'd2, 16'h0, ak, 1'b1);
      else if (sel < 13) begin
        RESET = 1'b1;
        step(1'b0, B + 16'd2, 16'h0, ak, 1'b0);
        RESET = 1'b0;
      end else
        step(1'b0, B + 16'd2, 16'h0, ak, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
